// File: rtl/combo_lock_pkg.sv
// Shared definitions for the multi-digit combination lock: state encodings
// (which double as the status code seen by the hex display decoder) and
// width helpers used by the lock core.
package combo_lock_pkg;

  // Status encodings are consumed directly by the display decoder.
  typedef enum logic [2:0] {
    ST_LOCKED   = 3'd0,
    ST_OPEN     = 3'd1,
    ST_NEW_CODE = 3'd2,
    ST_CONFIRM  = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  localparam int STATUS_W = 3;

  // Width of the digit index; a one-digit code still gets a 1-bit index.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  // Width of a counter that must hold the value max_val inclusive.
  function automatic int count_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for a synchronous level button. The history register
// resets high, so a button that is already held when reset releases does not
// produce a press; it must be released and pressed again.
module edge_pulse (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  // Remember last cycle's level to detect a low-to-high transition.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/seq_combo_lock.sv
// Multi-digit combination lock core. A code of DIGITS digits, WIDTH bits
// each, is keyed one digit per enter press (digit 0 first). Consecutive
// failed attempts lead to a timed lockout; the code can be changed from OPEN
// with an enter-then-confirm sequence that a change press aborts.
module seq_combo_lock
  import combo_lock_pkg::*;
#(
  parameter int                          DIGITS         = 4,
  parameter int                          WIDTH          = 4,
  parameter int                          MAX_TRIES      = 3,
  parameter int                          LOCKOUT_CYCLES = 1024,
  parameter logic [DIGITS*WIDTH-1:0]     RESET_COMBO    = '0,
  localparam int                         IDX_W          = idx_width(DIGITS)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [WIDTH-1:0]      combo,
  input  logic                  enter,
  input  logic                  change,
  output logic [STATUS_W-1:0]   status,
  output logic                  is_open,
  output logic                  locked_out,
  output logic                  err,
  output logic [IDX_W-1:0]      digit_idx
);

  localparam int CODE_W = DIGITS * WIDTH;
  localparam int TRY_W  = count_width(MAX_TRIES);
  localparam int LCK_W  = count_width(LOCKOUT_CYCLES);

  // Control and datapath registers.
  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_mis;
  logic [TRY_W-1:0]    r_tries;
  logic [LCK_W-1:0]    r_lock_cnt;
  logic [CODE_W-1:0]   r_code;
  logic [CODE_W-1:0]   r_pend;
  logic                r_err;

  // Press strobes and per-digit comparisons.
  logic                w_enter_p;
  logic                w_change_p;
  logic                w_last;
  logic [WIDTH-1:0]    w_stored_digit;
  logic [WIDTH-1:0]    w_pend_digit;
  logic                w_mis_stored;
  logic                w_mis_pend;
  logic [TRY_W-1:0]    w_tries_inc;

  edge_pulse u_enter_edge (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_level (enter),
    .o_pulse (w_enter_p)
  );

  edge_pulse u_change_edge (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_level (change),
    .o_pulse (w_change_p)
  );

  // The digit addressed by the current index, from the stored and pending codes.
  assign w_stored_digit = r_code[int'(r_idx) * WIDTH +: WIDTH];
  assign w_pend_digit   = r_pend[int'(r_idx) * WIDTH +: WIDTH];
  assign w_mis_stored   = (combo != w_stored_digit);
  assign w_mis_pend     = (combo != w_pend_digit);
  assign w_last         = (r_idx == IDX_W'(DIGITS - 1));
  assign w_tries_inc    = r_tries + TRY_W'(1);

  // Lock state machine: digit sequencing, try counting, lockout timing and
  // the two-pass code change all advance together on a single press.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_LOCKED;
      r_idx      <= '0;
      r_mis      <= 1'b0;
      r_tries    <= '0;
      r_lock_cnt <= '0;
      r_code     <= RESET_COMBO;
      r_pend     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        ST_LOCKED: begin
          // change is meaningless while locked
          if (w_enter_p) begin
            if (w_last) begin
              r_idx <= '0;
              r_mis <= 1'b0;
              if (!(r_mis || w_mis_stored)) begin
                r_state <= ST_OPEN;
                r_tries <= '0;
              end else begin
                r_err   <= 1'b1;
                r_tries <= w_tries_inc;
                if (w_tries_inc == TRY_W'(MAX_TRIES)) begin
                  r_state    <= ST_LOCKOUT;
                  r_lock_cnt <= LCK_W'(LOCKOUT_CYCLES);
                end
              end
            end else begin
              r_idx <= r_idx + IDX_W'(1);
              r_mis <= r_mis | w_mis_stored;
            end
          end
        end

        ST_OPEN: begin
          // A code change takes priority over relocking on a simultaneous press.
          if (w_change_p) begin
            r_state <= ST_NEW_CODE;
            r_idx   <= '0;
            r_mis   <= 1'b0;
            r_pend  <= '0;
          end else if (w_enter_p) begin
            r_state <= ST_LOCKED;
            r_idx   <= '0;
            r_mis   <= 1'b0;
          end
        end

        ST_NEW_CODE: begin
          if (w_change_p) begin
            r_state <= ST_OPEN;
            r_idx   <= '0;
            r_mis   <= 1'b0;
            r_pend  <= '0;
          end else if (w_enter_p) begin
            r_pend[int'(r_idx) * WIDTH +: WIDTH] <= combo;
            if (w_last) begin
              r_state <= ST_CONFIRM;
              r_idx   <= '0;
              r_mis   <= 1'b0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end

        ST_CONFIRM: begin
          if (w_change_p) begin
            r_state <= ST_OPEN;
            r_idx   <= '0;
            r_mis   <= 1'b0;
            r_pend  <= '0;
          end else if (w_enter_p) begin
            if (w_last) begin
              // Either way the pending code is finished with; only a clean
              // confirmation replaces the stored code.
              if (!(r_mis || w_mis_pend)) begin
                r_code <= r_pend;
              end else begin
                r_err <= 1'b1;
              end
              r_state <= ST_OPEN;
              r_idx   <= '0;
              r_mis   <= 1'b0;
              r_pend  <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
              r_mis <= r_mis | w_mis_pend;
            end
          end
        end

        ST_LOCKOUT: begin
          // Leaving when the counter is at 1 keeps LOCKOUT visible for
          // exactly LOCKOUT_CYCLES cycles after the load.
          if (r_lock_cnt <= LCK_W'(1)) begin
            r_state    <= ST_LOCKED;
            r_lock_cnt <= '0;
            r_tries    <= '0;
            r_idx      <= '0;
            r_mis      <= 1'b0;
          end else begin
            r_lock_cnt <= r_lock_cnt - LCK_W'(1);
          end
        end

        default: begin
          r_state <= ST_LOCKED;
          r_idx   <= '0;
          r_mis   <= 1'b0;
        end
      endcase
    end
  end

  assign status     = r_state;
  assign is_open    = (r_state == ST_OPEN);
  assign locked_out = (r_state == ST_LOCKOUT);
  assign err        = r_err;
  assign digit_idx  = r_idx;

endmodule

// File: tb/tb_seq_combo_lock.sv
// Scoreboard bench for seq_combo_lock: stimulus tasks push the expected
// output vector for a given cycle; a negedge monitor pops and compares.
module tb_seq_combo_lock;

  localparam int         DIGITS         = 2;
  localparam int         WIDTH          = 4;
  localparam int         MAX_TRIES      = 2;
  localparam int         LOCKOUT_CYCLES = 8;
  localparam logic [7:0] RESET_COMBO    = 8'h21;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] combo;
  logic       enter;
  logic       change;
  logic [2:0] status;
  logic       is_open;
  logic       locked_out;
  logic       err;
  logic [0:0] digit_idx;

  seq_combo_lock #(
    .DIGITS         (DIGITS),
    .WIDTH          (WIDTH),
    .MAX_TRIES      (MAX_TRIES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .RESET_COMBO    (RESET_COMBO)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .combo      (combo),
    .enter      (enter),
    .change     (change),
    .status     (status),
    .is_open    (is_open),
    .locked_out (locked_out),
    .err        (err),
    .digit_idx  (digit_idx)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [2:0] st;
    logic       op;
    logic       lo;
    logic       er;
    logic       idx;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  exp_t  m_e;
  string m_nm;

  function automatic void push(input int at, input logic [2:0] st, input logic er,
                               input logic idx, input string nm);
    exp_t e;
    e.at  = at;
    e.st  = st;
    e.op  = (st == 3'd1);
    e.lo  = (st == 3'd4);
    e.er  = er;
    e.idx = idx;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge Clock) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      m_e  = exp_q.pop_front();
      m_nm = name_q.pop_front();
      n_chk++;
      if (m_e.at != cyc) begin
        $display("FAIL %s: expectation for cycle %0d not sampled (now cycle %0d)", m_nm, m_e.at, cyc);
      end else if ({status, is_open, locked_out, err, digit_idx} !==
                   {m_e.st, m_e.op, m_e.lo, m_e.er, m_e.idx}) begin
        $display("FAIL %s cyc %0d: got status=%0d open=%b lockout=%b err=%b idx=%0d, want status=%0d open=%b lockout=%b err=%b idx=%0d",
                 m_nm, cyc, status, is_open, locked_out, err, digit_idx,
                 m_e.st, m_e.op, m_e.lo, m_e.er, m_e.idx);
      end else begin
        n_pass++;
      end
    end
  end

  // One enter press with a low cycle after it; checks the press cycle and the one after.
  task automatic key(input logic [3:0] d, input logic [2:0] st, input logic er,
                     input logic idx, input string nm);
    combo = d;
    enter = 1'b1;
    push(cyc + 1, st, er, idx, nm);
    push(cyc + 2, st, 1'b0, idx, {nm, "_next"});
    @(posedge Clock); #1;
    enter = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic chg(input logic [2:0] st, input logic idx, input string nm);
    change = 1'b1;
    push(cyc + 1, st, 1'b0, idx, nm);
    push(cyc + 2, st, 1'b0, idx, {nm, "_next"});
    @(posedge Clock); #1;
    change = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic both(input logic [2:0] st, input logic idx, input string nm);
    enter  = 1'b1;
    change = 1'b1;
    push(cyc + 1, st, 1'b0, idx, nm);
    push(cyc + 2, st, 1'b0, idx, {nm, "_next"});
    @(posedge Clock); #1;
    enter  = 1'b0;
    change = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic idle(input int n, input logic [2:0] st, input string nm);
    for (int i = 0; i < n; i++) begin
      push(cyc + 1, st, 1'b0, 1'b0, nm);
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset  = 1'b1;
    enter  = 1'b0;
    change = 1'b0;
    combo  = 4'd0;
    @(posedge Clock); #1;
    push(cyc, 3'd0, 1'b0, 1'b0, "reset_state");
    @(posedge Clock); #1;
    push(cyc, 3'd0, 1'b0, 1'b0, "reset_state_hold");
    Reset = 1'b0;
    idle(1, 3'd0, "post_reset");

    // Unlock and relock; change is ignored while locked
    chg(3'd0, 1'b0, "locked_change_ignored");
    key(4'd1, 3'd0, 1'b0, 1'b1, "s1_digit0");
    key(4'd2, 3'd1, 1'b0, 1'b0, "s1_open");
    key(4'd0, 3'd0, 1'b0, 1'b0, "s1_relock");

    // Two failures -> lockout of exactly 8 cycles, presses ignored meanwhile
    key(4'd1, 3'd0, 1'b0, 1'b1, "s2_a_digit0");
    key(4'd3, 3'd0, 1'b1, 1'b0, "s2_a_fail");
    key(4'd5, 3'd0, 1'b0, 1'b1, "s2_b_digit0");
    key(4'd2, 3'd4, 1'b1, 1'b0, "s2_lockout_entry");
    key(4'd1, 3'd4, 1'b0, 1'b0, "s2_ignored_1");
    key(4'd2, 3'd4, 1'b0, 1'b0, "s2_ignored_2");
    idle(2, 3'd4, "s2_lockout_tail");
    idle(1, 3'd0, "s2_lockout_exit");
    // Try count was cleared by expiry: one failure must not lock out again
    key(4'd9, 3'd0, 1'b0, 1'b1, "s2_c_digit0");
    key(4'd9, 3'd0, 1'b1, 1'b0, "s2_fail_after_expiry");
    key(4'd1, 3'd0, 1'b0, 1'b1, "s2_d_digit0");
    key(4'd2, 3'd1, 1'b0, 1'b0, "s2_open");

    // Confirm mismatch keeps old code; abort after one digit
    chg(3'd2, 1'b0, "s4_new_code");
    key(4'd7, 3'd2, 1'b0, 1'b1, "s4_nc_digit0");
    key(4'd9, 3'd3, 1'b0, 1'b0, "s4_confirm");
    key(4'd7, 3'd3, 1'b0, 1'b1, "s4_cf_digit0");
    key(4'd8, 3'd1, 1'b1, 1'b0, "s4_confirm_mismatch");
    key(4'd0, 3'd0, 1'b0, 1'b0, "s4_relock");
    key(4'd1, 3'd0, 1'b0, 1'b1, "s4_old_digit0");
    key(4'd2, 3'd1, 1'b0, 1'b0, "s4_old_code_opens");
    chg(3'd2, 1'b0, "s4_new_code_again");
    key(4'd7, 3'd2, 1'b0, 1'b1, "s4_one_digit");
    chg(3'd1, 1'b0, "s4_abort");

    // Successful code change to 7,9
    chg(3'd2, 1'b0, "s3_new_code");
    key(4'd7, 3'd2, 1'b0, 1'b1, "s3_nc_digit0");
    key(4'd9, 3'd3, 1'b0, 1'b0, "s3_confirm");
    key(4'd7, 3'd3, 1'b0, 1'b1, "s3_cf_digit0");
    key(4'd9, 3'd1, 1'b0, 1'b0, "s3_commit");
    key(4'd0, 3'd0, 1'b0, 1'b0, "s3_relock");
    key(4'd1, 3'd0, 1'b0, 1'b1, "s3_old_digit0");
    key(4'd2, 3'd0, 1'b1, 1'b0, "s3_old_code_rejected");
    key(4'd7, 3'd0, 1'b0, 1'b1, "s3_new_digit0");
    key(4'd9, 3'd1, 1'b0, 1'b0, "s3_new_code_opens");

    // Held enter counts once
    key(4'd0, 3'd0, 1'b0, 1'b0, "s5_relock");
    combo = 4'd7;
    enter = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(cyc + 1, 3'd0, 1'b0, 1'b1, "s5_held_enter");
      @(posedge Clock); #1;
    end
    enter = 1'b0;
    push(cyc + 1, 3'd0, 1'b0, 1'b1, "s5_held_release");
    @(posedge Clock); #1;
    key(4'd9, 3'd1, 1'b0, 1'b0, "s5_held_counts_once");

    // Simultaneous enter+change in OPEN: change wins
    both(3'd2, 1'b0, "s5_both_change_wins");
    chg(3'd1, 1'b0, "s5_abort");
    key(4'd0, 3'd0, 1'b0, 1'b0, "s5_relock2");
    key(4'd7, 3'd0, 1'b0, 1'b1, "s5_partial");

    // Asynchronous reset mid-sequence, enter held through reset release
    @(posedge Clock); #1;
    Reset = 1'b1;
    enter = 1'b1;
    push(cyc, 3'd0, 1'b0, 1'b0, "s5_async_reset");
    @(posedge Clock); #1;
    push(cyc, 3'd0, 1'b0, 1'b0, "s5_reset_hold");
    Reset = 1'b0;
    @(posedge Clock); #1;
    push(cyc, 3'd0, 1'b0, 1'b0, "s5_held_through_reset");
    enter = 1'b0;
    @(posedge Clock); #1;
    push(cyc, 3'd0, 1'b0, 1'b0, "s5_after_reset");
    key(4'd1, 3'd0, 1'b0, 1'b1, "s5_rc_digit0");
    key(4'd2, 3'd1, 1'b0, 1'b0, "s5_reset_combo_restored");
    idle(3, 3'd1, "final_idle");

    repeat (2) @(posedge Clock);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
      n_chk = n_chk + exp_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
